// File: rtl/aes_inv_round.sv
// ---------------------------------------------------------------------------
// aes_inv_round -- one iterative AES decryption round per transaction.
//
// Round order: InvShiftRows (applied as the request is captured), InvSubBytes
// (LANES bytes per cycle through a bank of inverse S-box lanes), AddRoundKey,
// then InvMixColumns unless this is the final round.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, drops any round in flight
//   in_valid   round request valid
//   in_ready   high only in IDLE
//   in_state   128-bit round input, byte k = bits[127-8k -: 8] (column-major)
//   in_key     128-bit round key, same byte order
//   in_last    final round: skip InvMixColumns
//   out_valid  result held in out_state
//   out_ready  consumer accepts the result
//   out_state  round result, held until the next round's MIX cycle
//   busy       high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------

// One inverse S-box lane: inverse affine transform followed by the GF(2^8)
// multiplicative inverse (x^254, so 0 maps to 0 with no special case).
module aes_inv_sbox_lane (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] aff;

    // Inverse of the forward affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    always_comb begin
        aff  = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
        dout = ginv(aff);
    end

endmodule

module aes_inv_round #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_MIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // bytes_t[k] is state byte k (row k%4, column k/4)
    typedef logic [15:0][7:0] bytes_t;

    typedef struct packed {
        logic [127:0] key;
        logic         last;
    } req_t;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("aes_inv_round: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    function automatic bytes_t to_bytes(input logic [127:0] v);
        bytes_t b;
        for (int k = 0; k < 16; k++) b[k] = v[127-8*k -: 8];
        return b;
    endfunction

    function automatic logic [127:0] from_bytes(input bytes_t b);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[127-8*k -: 8] = b[k];
        return v;
    endfunction

    // new[r][c] = s[r][(c-r) mod 4]
    function automatic bytes_t inv_shift_rows(input bytes_t b);
        bytes_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4*c+r] = b[4*((c-r) & 3) + r];
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Fixed-coefficient multiplies built from one shared xtime chain
    function automatic logic [7:0] m09(input logic [7:0] a);
        return xt(xt(xt(a))) ^ a;
    endfunction

    function automatic logic [7:0] m0b(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(a) ^ a;
    endfunction

    function automatic logic [7:0] m0d(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
    endfunction

    function automatic logic [7:0] m0e(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
    endfunction

    // Row r of a column uses coefficients {0e,0b,0d,09} rotated by r
    function automatic bytes_t inv_mix_columns(input bytes_t b);
        bytes_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4*c+r] = m0e(b[4*c + r])           ^ m0b(b[4*c + ((r+1) & 3)]) ^
                           m0d(b[4*c + ((r+2) & 3)]) ^ m09(b[4*c + ((r+3) & 3)]);
        return o;
    endfunction

    logic [1:0]              fsm_q;
    logic [CW-1:0]           cnt_q;
    bytes_t                  st_q;
    req_t                    req_q;
    logic [127:0]            res_q;
    logic [LANES-1:0][3:0]   lane_idx;
    logic [LANES-1:0][7:0]   sb_in;
    logic [LANES-1:0][7:0]   sb_out;
    bytes_t                  mix_t;
    logic [127:0]            mix_res;

    // Lane j works on byte cnt*LANES + j of the current group
    genvar j;
    generate
        for (j = 0; j < LANES; j++) begin : g_lane
            assign lane_idx[j] = 4'(int'(cnt_q) * LANES + j);
            assign sb_in[j]    = st_q[lane_idx[j]];
            aes_inv_sbox_lane u_sbox (
                .din  (sb_in[j]),
                .dout (sb_out[j])
            );
        end
    endgenerate

    assign mix_t   = st_q ^ to_bytes(req_q.key);
    assign mix_res = from_bytes(req_q.last ? mix_t : inv_mix_columns(mix_t));

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= S_IDLE;
            cnt_q <= '0;
            st_q  <= '0;
            req_q <= '0;
            res_q <= '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (in_valid) begin
                        st_q      <= inv_shift_rows(to_bytes(in_state));
                        req_q.key  <= in_key;
                        req_q.last <= in_last;
                        cnt_q     <= '0;
                        fsm_q     <= S_SUB;
                    end
                end
                S_SUB: begin
                    for (int k = 0; k < LANES; k++) st_q[lane_idx[k]] <= sb_out[k];
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_q <= '0;
                        fsm_q <= S_MIX;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_MIX: begin
                    res_q <= mix_res;
                    fsm_q <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) fsm_q <= S_IDLE;
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm_q == S_IDLE);
    assign out_valid = (fsm_q == S_DONE);
    assign busy      = (fsm_q != S_IDLE);
    assign out_state = res_q;

endmodule

// File: tb/tb_aes_inv_round.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_round -- directed plus random rounds against a matrix-level AES
// decryption model. The model's inverse S-box is obtained by inverting a
// forward S-box table built from brute-force GF(2^8) inverses. Three DUTs
// (LANES = 1, 4, 16) share the request inputs; the LANES=4 instance carries
// the latency, backpressure and reset checks.
// ---------------------------------------------------------------------------
module tb_aes_inv_round;

    localparam int N4 = 16 / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
    logic         out_ready;
    logic         aux_rdy;

    logic         ir1, ov1, bz1;
    logic         ir4, ov4, bz4;
    logic         ir16, ov16, bz16;
    logic [127:0] os1, os4, os16;

    int checks   = 0;
    int failures = 0;

    logic [7:0] fwd_sb [256];
    logic [7:0] inv_sb [256];

    always #5 clk = ~clk;

    aes_inv_round #(.LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
        .in_state(in_state), .in_key(in_key), .in_last(in_last),
        .out_valid(ov1), .out_ready(aux_rdy), .out_state(os1), .busy(bz1));

    aes_inv_round #(.LANES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
        .in_state(in_state), .in_key(in_key), .in_last(in_last),
        .out_valid(ov4), .out_ready(out_ready), .out_state(os4), .busy(bz4));

    aes_inv_round #(.LANES(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
        .in_state(in_state), .in_key(in_key), .in_last(in_last),
        .out_valid(ov16), .out_ready(aux_rdy), .out_state(os16), .busy(bz16));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa;
            aa = (aa[7]) ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic void build_tables();
        logic [7:0] inv;
        logic [7:0] y;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            y = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            fwd_sb[x] = y;
        end
        for (int x = 0; x < 256; x++) inv_sb[fwd_sb[x]] = 8'(x);
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input logic l);
        logic [7:0]   m [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = inv_sb[m[r][(c - r + 4) % 4]] ^ k[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = l ? t[r][c] :
                    (gmul(8'h0e, t[r][c])           ^ gmul(8'h0b, t[(r+1)%4][c]) ^
                     gmul(8'h0d, t[(r+2)%4][c])     ^ gmul(8'h09, t[(r+3)%4][c]));
        return o;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request to an idle DUT, waits (bounded) for out_valid on the
    // LANES=4 instance, then lets the handshake edge pass.
    task automatic do_round(input logic [127:0] s, input logic [127:0] k, input logic l,
                            output logic [127:0] res, output int lat);
        in_state = s; in_key = k; in_last = l; in_valid = 1'b1; out_ready = 1'b1;
        lat = 0;
        res = 'x;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (!ov4 && lat < 50);
        if (ov4) res = os4;
        @(posedge clk); #1;
    endtask

    logic [127:0] s, k, exp, res, r1, r4, r16;
    logic         l;
    logic         g1, g4, g16;
    int           lat, cyc;

    initial begin
        build_tables();
        rst = 1'b1; in_valid = 1'b0; in_state = '0; in_key = '0; in_last = 1'b0;
        out_ready = 1'b1; aux_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  128'(ir4), 128'(1));
        check("rst_out_valid", 128'(ov4), 128'(0));
        check("rst_busy",      128'(bz4), 128'(0));
        check("rst_out_state", os4, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed rounds with hand-derived results
        do_round('0, '0, 1'b1, res, lat);
        check("zero_last", res, {16{8'h52}});
        check("zero_last_lat", 128'(lat), 128'(N4 + 2));
        check("post_hs_ready", 128'(ir4), 128'(1));
        do_round('0, '0, 1'b0, res, lat);
        check("zero_mix", res, {16{8'h52}});
        do_round('0, {16{8'hff}}, 1'b1, res, lat);
        check("key_ff", res, {16{8'had}});
        do_round(128'h637c777bf26b6fc53001672bfed7ab76, '0, 1'b1, res, lat);
        check("shiftrows_order", res, 128'h000d0a0704010e0b0805020f0c090603);

        // Random rounds against the model
        for (int i = 0; i < 24; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            l = 1'($urandom_range(0, 1));
            do_round(s, k, l, res, lat);
            check("rand_round", res, ref_round(s, k, l));
            check("rand_lat", 128'(lat), 128'(N4 + 2));
        end

        // Backpressure: result must hold and further requests be ignored
        s = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        exp = ref_round(s, k, 1'b0);
        out_ready = 1'b0;
        in_state = s; in_key = k; in_last = 1'b0; in_valid = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            cyc++;
        end while (!ov4 && cyc < 50);
        check("bp_first", os4, exp);
        in_state = ~s; in_key = ~k; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 128'(ov4), 128'(1));
            check("bp_hold", os4, exp);
            check("bp_not_ready", 128'(ir4), 128'(0));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drop_valid", 128'(ov4), 128'(0));
        check("bp_idle_ready", 128'(ir4), 128'(1));
        check("bp_idle_busy", 128'(bz4), 128'(0));
        check("bp_keep_state", os4, exp);

        // Reset in the middle of SUB discards the round
        in_state = {$urandom, $urandom, $urandom, $urandom}; in_key = '0; in_last = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ready", 128'(ir4), 128'(1));
        check("midrst_valid", 128'(ov4), 128'(0));
        check("midrst_busy",  128'(bz4), 128'(0));
        check("midrst_state", os4, '0);
        s = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        do_round(s, k, 1'b0, res, lat);
        check("after_rst_round", res, ref_round(s, k, 1'b0));
        // Let the other lane widths drain any leftover work
        repeat (40) @(posedge clk);
        #1;

        // Exhaustive inverse S-box across LANES = 1, 4, 16
        for (int x = 0; x < 256; x++) begin
            in_state = {16{fwd_sb[x]}}; in_key = '0; in_last = 1'b1;
            in_valid = 1'b1; out_ready = 1'b1;
            g1 = 1'b0; g4 = 1'b0; g16 = 1'b0;
            r1 = 'x; r4 = 'x; r16 = 'x;
            cyc = 0;
            @(posedge clk); #1;
            in_valid = 1'b0;
            while (!(g1 && g4 && g16) && cyc < 60) begin
                if (ov1  && !g1)  begin g1  = 1'b1; r1  = os1;  end
                if (ov4  && !g4)  begin g4  = 1'b1; r4  = os4;  end
                if (ov16 && !g16) begin g16 = 1'b1; r16 = os16; end
                @(posedge clk); #1;
                cyc++;
            end
            exp = {16{8'(x)}};
            check("sbox_l1",  r1,  exp);
            check("sbox_l4",  r4,  exp);
            check("sbox_l16", r16, exp);
        end
        check("final_idle", 128'({ir1, ir4, ir16, bz1, bz4, bz16}), 128'(6'b111000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
